// File: rtl/alu_pkg.sv
// Shared opcode/FSM encodings and special divide results for seq_alu.
// Result constants are MAX_W wide and sliced to the datapath width by users.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_AND    = 5'd0,
      OP_OR     = 5'd1,
      OP_ADD    = 5'd2,
      OP_SUB    = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_MUL    = 5'd8,
      OP_MULH   = 5'd9,
      OP_MULHSU = 5'd10,
      OP_MULHU  = 5'd11,
      OP_DIV    = 5'd12,
      OP_DIVU   = 5'd13,
      OP_REM    = 5'd14,
      OP_REMU   = 5'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   localparam int unsigned MAX_W = 64;
   // quotient on divide-by-zero, remainder on signed overflow
   localparam logic [MAX_W-1:0] DIVZ_Q  = '1;
   localparam logic [MAX_W-1:0] OVF_REM = '0;

   function automatic logic is_mul(input logic [4:0] o);
      return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic is_div(input logic [4:0] o);
      return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative W-cycle multiplier (radix-2 shift-add) and, with SEQ_ALU_DIV_EN,
// restoring divider. Works on magnitudes; signs are reapplied on the way out.
module seq_muldiv import alu_pkg::*; #(
   parameter int W    = 32,
   parameter int SH_W = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [4:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] result
);

   logic            active, neg_q;
   logic [SH_W-1:0] cnt;
   logic [4:0]      op_q;
   // hi: partial product / remainder, lo: multiplier / dividend-quotient
   logic [W-1:0]    hi, lo, mc, hi_n, lo_n;
   logic [W:0]      msum;
   logic [2*W-1:0]  prod, sprod;
   logic            a_neg, b_neg;
   logic [W-1:0]    a_mag, b_mag;

   always_comb begin
      a_neg = a[W-1] & (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      b_neg = b[W-1] & (op inside {OP_MULH, OP_DIV, OP_REM});
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   assign done = active & (&cnt);

`ifdef SEQ_ALU_DIV_EN
   logic         neg_r, dz_q, ovf_q;
   logic [W-1:0] a_q, ddif, quo, rmd;
   logic [W:0]   dtry;
   logic         dge;

   assign dtry = {hi, lo[W-1]};
   assign dge  = dtry >= {1'b0, mc};
   assign ddif = dtry[W-1:0] - mc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_r <= 1'b0;
         dz_q  <= 1'b0;
         ovf_q <= 1'b0;
         a_q   <= '0;
      end else if (start) begin
         neg_r <= a_neg;
         dz_q  <= (b == '0);
         ovf_q <= (op == OP_DIV || op == OP_REM) &&
                  (a == {1'b1, {(W-1){1'b0}}}) && (&b);
         a_q   <= a;
      end
   end
`endif

   always_comb begin
      msum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
      hi_n = msum[W:1];
      lo_n = {msum[0], lo[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
      if (is_div(op_q)) begin
         hi_n = dge ? ddif : dtry[W-1:0];
         lo_n = {lo[W-2:0], dge};
      end
`endif
   end

   // result reflects the step being applied this cycle, so it is valid with done
   always_comb begin
      prod   = {hi_n, lo_n};
      sprod  = neg_q ? -prod : prod;
      result = (op_q == OP_MUL) ? sprod[W-1:0] : sprod[2*W-1:W];
`ifdef SEQ_ALU_DIV_EN
      quo = neg_q ? -lo_n : lo_n;
      rmd = neg_r ? -hi_n : hi_n;
      if (op_q == OP_DIV || op_q == OP_DIVU)
         result = dz_q ? DIVZ_Q[W-1:0] : (ovf_q ? a_q : quo);
      else if (op_q == OP_REM || op_q == OP_REMU)
         result = dz_q ? a_q : (ovf_q ? OVF_REM[W-1:0] : rmd);
`else
      quo_unused();
`endif
   end

`ifndef SEQ_ALU_DIV_EN
   function automatic void quo_unused();
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         cnt    <= '0;
         op_q   <= '0;
         hi     <= '0;
         lo     <= '0;
         mc     <= '0;
         neg_q  <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         op_q   <= op;
         hi     <= '0;
         lo     <= a_mag;
         mc     <= b_mag;
         neg_q  <= a_neg ^ b_neg;
      end else if (active) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle base ops, W-cycle mul (and div with
// SEQ_ALU_DIV_EN) via seq_muldiv, valid/ready handshake on both sides.
module seq_alu import alu_pkg::*; #(
   parameter int W    = 32,
   parameter int SH_W = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] C,
   output logic         zero,
   output logic         sgn,
   output logic         busy
);

   alu_state_e   state, state_n;
   logic [W-1:0] c_q, c_n, base_res, md_res;
   logic         accept, iter, md_start, md_done;
   logic [SH_W-1:0] sh;

   assign sh = B[SH_W-1:0];

   always_comb begin
      iter = is_mul(op);
`ifdef SEQ_ALU_DIV_EN
      iter = iter | is_div(op);
`endif
   end

   always_comb begin
      base_res = '0;
      case (op)
         OP_AND:  base_res = A & B;
         OP_OR:   base_res = A | B;
         OP_ADD:  base_res = A + B;
         OP_SUB:  base_res = A - B;
         OP_XOR:  base_res = A ^ B;
         OP_SLL:  base_res = A << sh;
         OP_SRL:  base_res = A >> sh;
         OP_SRA:  base_res = $unsigned($signed(A) >>> sh);
         default: base_res = '0;
      endcase
   end

   seq_muldiv #(.W(W), .SH_W(SH_W)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .op     (op),
      .a      (A),
      .b      (B),
      .done   (md_done),
      .result (md_res)
   );

   always_comb begin
      state_n  = state;
      c_n      = c_q;
      md_start = 1'b0;
      in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
      accept   = in_valid & in_ready;
      if (state == ST_CALC) begin
         if (md_done) begin
            state_n = ST_DONE;
            c_n     = md_res;
         end
      end else if (accept) begin
         if (iter) begin
            state_n  = ST_CALC;
            md_start = 1'b1;
         end else begin
            state_n = ST_DONE;
            c_n     = base_res;
         end
      end else if (state == ST_DONE && out_ready) begin
         state_n = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         c_q   <= '0;
      end else begin
         state <= state_n;
         c_q   <= c_n;
      end
   end

   assign C         = c_q;
   assign zero      = (c_q == '0);
   assign sgn       = c_q[W-1];
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_CALC);

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic model.
// Divide expectations follow SEQ_ALU_DIV_EN like the design build.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [4:0]   op = '0;
   logic [W-1:0] A = '0, B = '0;
   logic         in_ready, out_valid, zero, sgn, busy;
   logic [W-1:0] C;
   int           n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   seq_alu #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .C(C), .zero(zero), .sgn(sgn), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic iterative(input logic [4:0] o);
      logic r;
      r = (o >= 5'd8 && o <= 5'd11);
`ifdef SEQ_ALU_DIV_EN
      r = r | (o >= 5'd12 && o <= 5'd15);
`endif
      return r;
   endfunction

   function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic [31:0] r;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      r   = '0;
      case (o)
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_ADD:    r = a + b;
         OP_SUB:    r = a - b;
         OP_XOR:    r = a ^ b;
         OP_SLL:    r = a << b[4:0];
         OP_SRL:    r = a >> b[4:0];
         OP_SRA:    r = 32'($signed(a) >>> b[4:0]);
         OP_MUL:    begin p = ua * ub; r = p[31:0];  end
         OP_MULH:   begin p = sa * sb; r = p[63:32]; end
         OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
         OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
`ifdef SEQ_ALU_DIV_EN
         OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
         OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    r = (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
         OP_REMU:   r = (b == 0) ? a : a % b;
`endif
         default:   r = '0;
      endcase
      if (ovf && p == 64'h1) r = r;
      return r;
   endfunction

   task automatic scramble();
      in_valid = 1'($urandom_range(0, 1));
      op       = 5'($urandom);
      A        = $urandom;
      B        = $urandom;
   endtask

   task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      scramble();
   endtask

   task automatic finish_op(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      int cyc, bcnt;
      logic [31:0] e;
      cyc  = 1;
      bcnt = 0;
      e    = model(o, a, b);
      while (!out_valid && cyc < 3*W) begin
         if (busy) bcnt++;
         @(negedge clk);
         scramble();
         cyc++;
      end
      chk({tag, ".lat"},  64'(cyc),  iterative(o) ? 64'(W+1) : 64'd1);
      chk({tag, ".busy"}, 64'(bcnt), iterative(o) ? 64'(W)   : 64'd0);
      chk({tag, ".C"},    64'(C),    64'(e));
      chk({tag, ".zero"}, 64'(zero), 64'(e == 0));
      chk({tag, ".sgn"},  64'(sgn),  64'(e[31]));
   endtask

   task automatic consume(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, ".idle"}, 64'(out_valid), 64'd0);
      out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      chk({tag, ".ir"}, 64'(in_ready), 64'd1);
      issue(o, a, b);
      finish_op(tag, o, a, b);
      consume(tag);
   endtask

   function automatic logic [31:0] pick_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [4:0]  ro, o;
      logic [31:0] a, b;
      int          cnt;

      #12;
      chk("rst.ov",   64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy),      64'd0);
      chk("rst.C",    64'(C),         64'd0);
      chk("rst.zero", 64'(zero),      64'd1);
      chk("rst.sgn",  64'(sgn),       64'd0);
      chk("rst.ir",   64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h1);
      run("sra",      OP_SRA,  32'h8000_0000, 32'h24);
      run("sub_wrap", OP_SUB,  32'h0,         32'h1);
      run("sll",      OP_SLL,  32'h1,         32'h21);
      run("and_zero", OP_AND,  32'hF0,        32'h0F);
      run("mulh",     OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("mulhu",    OP_MULHU,32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("mulhsu",   OP_MULHSU,32'h8000_0000,32'hFFFF_FFFF);
      run("mul",      OP_MUL,  32'hFFFF_FFF9, 32'h0000_0013);
      run("div_z",    OP_DIV,  32'h7,         32'h0);
      run("rem_z",    OP_REM,  32'h7,         32'h0);
      run("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      run("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
      run("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'h2);
      run("undef1f",  5'h1F,   32'h1234_5678, 32'h1);
      run("undef10",  5'h10,   32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // result held under backpressure, then back-to-back acceptance
      issue(OP_ADD, 32'h1, 32'h2);
      finish_op("hold", OP_ADD, 32'h1, 32'h2);
      repeat (5) begin
         @(negedge clk);
         scramble();
         chk("hold.C",  64'(C),         64'd3);
         chk("hold.ir", 64'(in_ready),  64'd0);
         chk("hold.ov", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b1; op = OP_AND; A = 32'hF0; B = 32'h3C; out_ready = 1'b1;
      @(negedge clk);
      chk("b2b.ov", 64'(out_valid), 64'd1);
      chk("b2b.C",  64'(C),         64'h30);
      consume("b2b");

      // reset in the middle of an iterative op
`ifdef SEQ_ALU_DIV_EN
      ro = OP_DIVU;
`else
      ro = OP_MULHU;
`endif
      issue(ro, 32'd1000, 32'd7);
      repeat (9) begin
         @(negedge clk);
         scramble();
      end
      chk("rst_mid.busy_pre", 64'(busy), 64'd1);
      #2;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_mid.ov",   64'(out_valid), 64'd0);
      chk("rst_mid.busy", 64'(busy),      64'd0);
      chk("rst_mid.C",    64'(C),         64'd0);
      chk("rst_mid.zero", 64'(zero),      64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cnt   = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      chk("rst_mid.no_result", 64'(cnt), 64'd0);
      run("rst_after", ro, 32'd1000, 32'd7);

      for (int i = 0; i < 80; i++) begin
         cnt = int'($urandom_range(0, 19));
         o   = (cnt >= 16) ? 5'($urandom_range(16, 31)) : 5'(cnt);
         a   = pick_opnd();
         b   = pick_opnd();
         run($sformatf("rnd%0d_op%0d", i, o), o, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
